// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one serial frame transmitter among CHANNELS requesters.
// Each frame carries {channel ID, data}; a watchdog aborts a WAIT that never sees txDone.
module serial_tx_arbiter #(
    parameter int CHANNELS       = 4,
    parameter int DATA_WIDTH     = 14,
    parameter int ID_WIDTH       = $clog2(CHANNELS),
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            reqValid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] reqData,
    output logic [CHANNELS-1:0]            reqReady,
    output logic                           frameStart,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] frameData,
    input  logic                           txDone,
    output logic                           busy,
    output logic [ID_WIDTH-1:0]            activeChannel,
    output logic                           timeoutError
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam state_t           DONE_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t                  state_r;
    logic [ID_WIDTH-1:0]     last_r;
    logic [TO_W-1:0]         to_cnt_r;
    logic [GAP_W-1:0]        gap_cnt_r;

    logic [CHANNELS-1:0]     grant_s;
    logic [ID_WIDTH-1:0]     grant_id_s;
    logic [DATA_WIDTH-1:0]   grant_data_s;
    logic [ID_WIDTH-1:0]     idx_s;
    logic                    hit_s;
    logic                    found_s;
    logic                    accept_s;

    // Round-robin search starting one past the last served channel, with wrap-around.
    always_comb begin
        grant_s      = {CHANNELS{1'b0}};
        grant_id_s   = {ID_WIDTH{1'b0}};
        grant_data_s = {DATA_WIDTH{1'b0}};
        idx_s        = {ID_WIDTH{1'b0}};
        hit_s        = 1'b0;
        found_s      = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx_s          = ID_WIDTH'((int'(last_r) + k) % CHANNELS);
            hit_s          = reqValid[idx_s] & ~found_s;
            grant_s[idx_s] = hit_s;
            grant_id_s     = hit_s ? idx_s : grant_id_s;
            grant_data_s   = hit_s ? reqData[idx_s*DATA_WIDTH +: DATA_WIDTH] : grant_data_s;
            found_s        = found_s | hit_s;
        end
    end

    assign reqReady = (state_r == ST_IDLE) ? grant_s : {CHANNELS{1'b0}};
    assign accept_s = (state_r == ST_IDLE) & found_s;

    // Frame sequencing FSM; txDone is only honoured in WAIT and beats the watchdog on a tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            last_r        <= ID_WIDTH'(CHANNELS - 1);
            to_cnt_r      <= {TO_W{1'b0}};
            gap_cnt_r     <= {GAP_W{1'b0}};
            frameStart    <= 1'b0;
            frameData     <= {(ID_WIDTH+DATA_WIDTH){1'b0}};
            busy          <= 1'b0;
            activeChannel <= {ID_WIDTH{1'b0}};
            timeoutError  <= 1'b0;
        end else begin
            frameStart   <= 1'b0;
            timeoutError <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        frameData     <= {grant_id_s, grant_data_s};
                        activeChannel <= grant_id_s;
                        last_r        <= grant_id_s;
                        frameStart    <= 1'b1;
                        busy          <= 1'b1;
                        state_r       <= ST_LAUNCH;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    to_cnt_r <= {TO_W{1'b0}};
                    state_r  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (txDone || (to_cnt_r == TO_LIMIT)) begin
                        timeoutError <= ~txDone;
                        gap_cnt_r    <= GAP_LOAD;
                        busy         <= (DONE_STATE != ST_IDLE);
                        state_r      <= DONE_STATE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == {GAP_W{1'b0}}) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench: dut0 runs default parameters, dut1 uses an 8-cycle watchdog and 2-cycle gap.
module tb_serial_tx_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  reqValid;
    logic [55:0] reqData;
    logic        td0, td1;
    logic [3:0]  rr0, rr1;
    logic        fs0, fs1, busy0, busy1, te0, te1;
    logic [15:0] fd0, fd1;
    logic [1:0]  ac0, ac1;

    int checks = 0;
    int errors = 0;

    serial_tx_arbiter dut0 (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqData(reqData),
        .reqReady(rr0), .frameStart(fs0), .frameData(fd0), .txDone(td0),
        .busy(busy0), .activeChannel(ac0), .timeoutError(te0)
    );

    serial_tx_arbiter #(.TIMEOUT_CYCLES(8), .GAP_CYCLES(2)) dut1 (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqData(reqData),
        .reqReady(rr1), .frameStart(fs1), .frameData(fd1), .txDone(td1),
        .busy(busy1), .activeChannel(ac1), .timeoutError(te1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        td0   = 1'b0;
        td1   = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // One complete dut0 frame from IDLE: accept, launch, txDone after 3 WAIT edges, 16-cycle gap.
    task automatic serve0(input int ch, input logic [15:0] fd);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        #1;
        check("rr_grant", 32'(rr0), 32'(oh));
        step();
        check("rr_chan", 32'(ac0), 32'(ch));
        check("rr_data", 32'(fd0), 32'(fd));
        check("rr_start", 32'(fs0), 32'd1);
        step();
        check("rr_start_low", 32'(fs0), 32'd0);
        step();
        step();
        td0 = 1'b1;
        step();
        td0 = 1'b0;
        repeat (15) step();
        check("rr_gap_busy", 32'(busy0), 32'd1);
        step();
        check("rr_idle", 32'(busy0), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        reqValid = 4'b0000;
        reqData  = 56'd0;
        td0      = 1'b0;
        td1      = 1'b0;
        step();
        check("rst_start", 32'(fs0), 32'd0);
        check("rst_data", 32'(fd0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_chan", 32'(ac0), 32'd0);
        check("rst_err", 32'(te0), 32'd0);
        check("rst_ready", 32'(rr0), 32'd0);
        reset = 1'b0;

        // Single request on channel 2, txDone 20 cycles into WAIT.
        reqData[28 +: 14] = 14'h1234;
        reqValid = 4'b0100;
        #1;
        check("t1_ready", 32'(rr0), 32'h4);
        step();
        check("t1_start", 32'(fs0), 32'd1);
        check("t1_data", 32'(fd0), 32'h9234);
        check("t1_chan", 32'(ac0), 32'd2);
        check("t1_ready_busy", 32'(rr0), 32'd0);
        reqValid = 4'b0000;
        step();
        check("t1_start_low", 32'(fs0), 32'd0);
        repeat (19) step();
        td0 = 1'b1;
        step();
        td0 = 1'b0;
        check("t1_gap_enter", 32'(busy0), 32'd1);
        repeat (15) step();
        check("t1_gap_last", 32'(busy0), 32'd1);
        check("t1_data_hold", 32'(fd0), 32'h9234);
        step();
        check("t1_idle", 32'(busy0), 32'd0);

        // All four channels valid: strict rotation 0,1,2,3,0.
        do_reset();
        reqData  = {14'h3333, 14'h2222, 14'h1111, 14'h0AAA};
        reqValid = 4'b1111;
        serve0(0, 16'h0AAA);
        serve0(1, 16'h5111);
        serve0(2, 16'hA222);
        serve0(3, 16'hF333);
        serve0(0, 16'h0AAA);

        // After channel 2, channels 1 and 3 pending: 3 wins, then 1.
        do_reset();
        reqValid = 4'b0100;
        serve0(2, 16'hA222);
        reqValid = 4'b1010;
        serve0(3, 16'hF333);
        serve0(1, 16'h5111);

        // Watchdog on dut1: abort 8 cycles after LAUNCH, 2-cycle gap, pending request re-accepted.
        do_reset();
        reqValid = 4'b0001;
        #1;
        check("to_ready", 32'(rr1), 32'h1);
        step();
        check("to_start", 32'(fs1), 32'd1);
        step();
        check("to_start_low", 32'(fs1), 32'd0);
        repeat (7) step();
        check("to_no_err_early", 32'(te1), 32'd0);
        check("to_busy_wait", 32'(busy1), 32'd1);
        step();
        check("to_err_pulse", 32'(te1), 32'd1);
        step();
        check("to_err_once", 32'(te1), 32'd0);
        check("to_gap_busy", 32'(busy1), 32'd1);
        step();
        check("to_idle", 32'(busy1), 32'd0);
        check("to_pending", 32'(rr1), 32'h1);
        step();
        check("to_reaccept", 32'(fs1), 32'd1);
        check("to_reaccept_chan", 32'(ac1), 32'd0);
        check("to_reaccept_data", 32'(fd1), 32'h0AAA);

        // txDone on the same edge as the watchdog limit: no error.
        reqValid = 4'b0000;
        step();
        repeat (7) step();
        td1 = 1'b1;
        step();
        td1 = 1'b0;
        check("tie_no_err", 32'(te1), 32'd0);
        check("tie_gap", 32'(busy1), 32'd1);
        step();
        step();
        check("tie_idle", 32'(busy1), 32'd0);

        // txDone during LAUNCH is ignored: WAIT runs to the watchdog.
        reqValid = 4'b0010;
        #1;
        step();
        check("ln_chan", 32'(ac1), 32'd1);
        td1 = 1'b1;
        reqValid = 4'b0000;
        step();
        td1 = 1'b0;
        check("ln_wait_busy", 32'(busy1), 32'd1);
        repeat (7) step();
        check("ln_still_wait", 32'(busy1), 32'd1);
        check("ln_no_err", 32'(te1), 32'd0);
        step();
        check("ln_err", 32'(te1), 32'd1);

        // Asynchronous reset during WAIT, then channel 0 wins the next grant.
        do_reset();
        reqValid = 4'b1000;
        #1;
        step();
        check("ar_chan3", 32'(ac0), 32'd3);
        check("ar_data3", 32'(fd0), 32'hF333);
        step();
        step();
        step();
        reqValid = 4'b1001;
        reset = 1'b1;
        #1;
        check("ar_start", 32'(fs0), 32'd0);
        check("ar_data", 32'(fd0), 32'd0);
        check("ar_busy", 32'(busy0), 32'd0);
        check("ar_chan", 32'(ac0), 32'd0);
        check("ar_err", 32'(te0), 32'd0);
        check("ar_ready", 32'(rr0), 32'h1);
        reset = 1'b0;
        step();
        check("ar_next_start", 32'(fs0), 32'd1);
        check("ar_next_chan", 32'(ac0), 32'd0);
        check("ar_next_data", 32'(fd0), 32'h0AAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
